// File: rtl/r4_ifft_pkg.sv
// Shared constants, quadrant type and cos-table generator for the radix-4 IFFT pipeline.
package r4_ifft_pkg;

  localparam int WIDTH_DEF    = 26;
  localparam int TW_WIDTH_DEF = 16;
  localparam int N_DEF        = 2048;
  localparam int TW_FRAC      = 14;
  localparam int TW_ONE       = 16384;
  localparam int RND_OFFSET   = 8192;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quadrant_e;

  // Quarter-wave entries are all non-negative, so +0.5 then truncate rounds to nearest.
  function automatic int cos_entry(input int m, input int n);
    real theta;
    theta = 2.0 * 3.14159265358979323846 * real'(m) / real'(n);
    return $rtoi(real'(TW_ONE) * $cos(theta) + 0.5);
  endfunction

endpackage

// File: rtl/r4_twiddle_rom.sv
// Registered quarter-wave cos table with quadrant folding; (cos, sin) of 2*pi*k/N one cycle after k.
module r4_twiddle_rom
  import r4_ifft_pkg::*;
#(
  parameter int TW_WIDTH = TW_WIDTH_DEF,
  parameter int N        = N_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [$clog2(N)-1:0]       k_i,
  output logic signed [TW_WIDTH-1:0] cos_o,
  output logic signed [TW_WIDTH-1:0] sin_o
);

  localparam int KW  = $clog2(N);
  localparam int RW  = KW - 2;
  localparam int QTR = N / 4;

  logic signed [TW_WIDTH-1:0] tab_s [0:QTR];
  quadrant_e                  q_s;
  logic [RW:0]                r_s;
  logic [RW:0]                rc_s;
  logic signed [TW_WIDTH-1:0] a_s;
  logic signed [TW_WIDTH-1:0] b_s;
  logic signed [TW_WIDTH-1:0] cos_d;
  logic signed [TW_WIDTH-1:0] sin_d;
  logic signed [TW_WIDTH-1:0] cos_q;
  logic signed [TW_WIDTH-1:0] sin_q;

  for (genvar m = 0; m <= QTR; m++) begin : g_tab
    assign tab_s[m] = TW_WIDTH'(cos_entry(m, N));
  end

  assign q_s  = quadrant_e'(k_i[KW-1 -: 2]);
  assign r_s  = {1'b0, k_i[RW-1:0]};
  assign rc_s = (RW+1)'(QTR) - r_s;
  assign a_s  = tab_s[r_s];
  assign b_s  = tab_s[rc_s];

  always_comb begin
    cos_d = a_s;
    sin_d = b_s;
    case (q_s)
      Q0: begin cos_d = a_s;  sin_d = b_s;  end
      Q1: begin cos_d = -b_s; sin_d = a_s;  end
      Q2: begin cos_d = -a_s; sin_d = -b_s; end
      Q3: begin cos_d = b_s;  sin_d = -a_s; end
      default: begin cos_d = a_s; sin_d = b_s; end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cos_q <= '0;
      sin_q <= '0;
    end else begin
      cos_q <= cos_d;
      sin_q <= sin_d;
    end
  end

  assign cos_o = cos_q;
  assign sin_o = sin_q;

endmodule

// File: rtl/r4_twiddle_mult.sv
// Three-stage twiddle rotation y = x * exp(+j*2*pi*k/N) between radix-4 SDF stages.
// Define R4_TWM_CONV_ROUND_EN for round-half-to-even in the final stage (default: round half-up).
module r4_twiddle_mult
  import r4_ifft_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int TW_WIDTH = TW_WIDTH_DEF,
  parameter int N        = N_DEF,
  parameter int ADDR_W   = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] data_in_r,
  input  logic signed [WIDTH-1:0] data_in_i,
  input  logic                    VALID,
  input  logic [ADDR_W-1:0]       radix_address,
  output logic signed [WIDTH-1:0] data_out_r,
  output logic signed [WIDTH-1:0] data_out_i,
  output logic                    OUT_VALID,
  output logic                    frame_done,
  output logic                    overflow
);

  localparam int KW = $clog2(N);
  localparam int PW = WIDTH + TW_WIDTH;
  localparam int SW = PW + 1;
  localparam logic [TW_FRAC-1:0]   HALF  = TW_FRAC'(RND_OFFSET);
  localparam logic signed [SW-1:0] MAX_V = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_V = ~MAX_V;

  logic [KW-1:0]              k_s;
  logic                       unused_addr_s;
  logic signed [TW_WIDTH-1:0] cos_s;
  logic signed [TW_WIDTH-1:0] sin_s;
  logic                       v1_q;
  logic signed [WIDTH-1:0]    xr1_q;
  logic signed [WIDTH-1:0]    xi1_q;
  logic                       v2_q;
  logic signed [PW-1:0]       p_rc_q;
  logic signed [PW-1:0]       p_is_q;
  logic signed [PW-1:0]       p_rs_q;
  logic signed [PW-1:0]       p_ic_q;
  logic signed [SW-1:0]       yr_rnd_s;
  logic signed [SW-1:0]       yi_rnd_s;
  logic signed [WIDTH-1:0]    yr_s;
  logic signed [WIDTH-1:0]    yi_s;
  logic                       sat_r_s;
  logic                       sat_i_s;
  logic signed [WIDTH-1:0]    out_r_d, out_r_q;
  logic signed [WIDTH-1:0]    out_i_d, out_i_q;
  logic                       out_v_q;
  logic                       fd_d, fd_q;
  logic                       ovf_d, ovf_q;
  logic [KW-1:0]              cnt_d, cnt_q;

  // Drop by 2^14 back to sample scale; ties go up, or to even when the option is built in.
  function automatic logic signed [SW-1:0] round_q14(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] t;
    logic                 up;
    t = s >>> TW_FRAC;
`ifdef R4_TWM_CONV_ROUND_EN
    up = (s[TW_FRAC-1:0] > HALF) || ((s[TW_FRAC-1:0] == HALF) && t[0]);
`else
    up = (s[TW_FRAC-1:0] >= HALF);
`endif
    return t + SW'(up);
  endfunction

  assign k_s           = radix_address[KW-1:0];
  assign unused_addr_s = ^radix_address;

  r4_twiddle_rom #(
    .TW_WIDTH (TW_WIDTH),
    .N        (N)
  ) u_rom (
    .clk_i (clk),
    .rst_i (rst),
    .k_i   (k_s),
    .cos_o (cos_s),
    .sin_o (sin_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      xr1_q <= '0;
      xi1_q <= '0;
    end else begin
      v1_q  <= VALID;
      xr1_q <= data_in_r;
      xi1_q <= data_in_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q   <= 1'b0;
      p_rc_q <= '0;
      p_is_q <= '0;
      p_rs_q <= '0;
      p_ic_q <= '0;
    end else begin
      v2_q   <= v1_q;
      p_rc_q <= PW'(xr1_q) * PW'(cos_s);
      p_is_q <= PW'(xi1_q) * PW'(sin_s);
      p_rs_q <= PW'(xr1_q) * PW'(sin_s);
      p_ic_q <= PW'(xi1_q) * PW'(cos_s);
    end
  end

  always_comb begin
    yr_rnd_s = round_q14(SW'(p_rc_q) - SW'(p_is_q));
    yi_rnd_s = round_q14(SW'(p_rs_q) + SW'(p_ic_q));
    sat_r_s  = 1'b0;
    sat_i_s  = 1'b0;
    yr_s     = yr_rnd_s[WIDTH-1:0];
    yi_s     = yi_rnd_s[WIDTH-1:0];
    if (yr_rnd_s > MAX_V) begin
      yr_s = MAX_V[WIDTH-1:0]; sat_r_s = 1'b1;
    end else if (yr_rnd_s < MIN_V) begin
      yr_s = MIN_V[WIDTH-1:0]; sat_r_s = 1'b1;
    end else begin
      yr_s = yr_rnd_s[WIDTH-1:0];
    end
    if (yi_rnd_s > MAX_V) begin
      yi_s = MAX_V[WIDTH-1:0]; sat_i_s = 1'b1;
    end else if (yi_rnd_s < MIN_V) begin
      yi_s = MIN_V[WIDTH-1:0]; sat_i_s = 1'b1;
    end else begin
      yi_s = yi_rnd_s[WIDTH-1:0];
    end
  end

  // Only valid samples update data, overflow and the frame counter; idle cycles hold.
  always_comb begin
    out_r_d = out_r_q;
    out_i_d = out_i_q;
    ovf_d   = ovf_q;
    fd_d    = 1'b0;
    cnt_d   = cnt_q;
    if (v2_q) begin
      out_r_d = yr_s;
      out_i_d = yi_s;
      ovf_d   = ovf_q | sat_r_s | sat_i_s;
      fd_d    = (cnt_q == KW'(N - 1));
      cnt_d   = fd_d ? '0 : cnt_q + KW'(1);
    end else begin
      fd_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_v_q <= 1'b0;
      out_r_q <= '0;
      out_i_q <= '0;
      fd_q    <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      out_v_q <= v2_q;
      out_r_q <= out_r_d;
      out_i_q <= out_i_d;
      fd_q    <= fd_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_out_r = out_r_q;
  assign data_out_i = out_i_q;
  assign OUT_VALID  = out_v_q;
  assign frame_done = fd_q;
  assign overflow   = ovf_q;

endmodule
